// File: rtl/rpn_lexer.sv
//------------------------------------------------------------------------------
// Module     : rpn_lexer
// Description: ASCII-to-RPN tokenizer. Turns received UART characters into
//              operand / operator / evaluate / clear / error tokens and hands
//              them to the RPN evaluator over a valid/ready handshake.
//              A one-byte input register and a two-entry token FIFO absorb
//              consumer stalls, because the byte stream cannot be held off.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_rx_done, i_rx_data    received-character strobe and data
//   o_tok_valid/i_tok_ready token handshake (FIFO head)
//   o_tok_type, o_tok_value token type (0 NUM..7 ERROR) and value
//   o_overrun               one-cycle pulse when a received byte is dropped
//   o_tx_start, o_tx_data   echo request to the UART transmitter
//   i_tx_done               UART transmitter finished
// Build option:
//   RPN_LEXER_ECHO_EN       when defined, every captured byte is echoed
//------------------------------------------------------------------------------
`default_nettype none

module rpn_lexer #(
  parameter int DATA_BITS   = 8,
  parameter int VALUE_WIDTH = 32,
  parameter int MAX_DIGITS  = 9
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx_done,
  input  logic [DATA_BITS-1:0]   i_rx_data,
  output logic                   o_tok_valid,
  input  logic                   i_tok_ready,
  output logic [2:0]             o_tok_type,
  output logic [VALUE_WIDTH-1:0] o_tok_value,
  output logic                   o_overrun,
  output logic                   o_tx_start,
  output logic [DATA_BITS-1:0]   o_tx_data,
  input  logic                   i_tx_done
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  localparam logic [2:0] TOK_NUM   = 3'd0;
  localparam logic [2:0] TOK_ADD   = 3'd1;
  localparam logic [2:0] TOK_SUB   = 3'd2;
  localparam logic [2:0] TOK_MUL   = 3'd3;
  localparam logic [2:0] TOK_DIV   = 3'd4;
  localparam logic [2:0] TOK_EVAL  = 3'd5;
  localparam logic [2:0] TOK_CLEAR = 3'd6;
  localparam logic [2:0] TOK_ERROR = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_NUM  = 1'b1
  } state_t;

  // Lexer state
  state_t                 state_q, state_d;
  logic [VALUE_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;

  // Input byte register
  logic [DATA_BITS-1:0]   byte_q, byte_d;
  logic                   byte_full_q, byte_full_d;
  logic                   overrun_q, overrun_d;

  // Token FIFO: entry 0 is always the head, entry 1 shifts down on pop
  logic [1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [2:0]             e0_type_q, e0_type_d, e1_type_q, e1_type_d;
  logic [VALUE_WIDTH-1:0] e0_val_q, e0_val_d, e1_val_q, e1_val_d;

  logic                   pop;
  logic                   consume;
  logic                   capture;

  // Character classification
  function automatic logic is_char(input logic [DATA_BITS-1:0] b, input logic [7:0] c);
    return b == DATA_BITS'(c);
  endfunction

  always_comb begin
    logic                   is_digit;
    logic                   is_ws;
    logic                   is_op;
    logic                   is_clear;
    logic [2:0]             op_type;
    logic [2:0]             opnd_type;
    logic [VALUE_WIDTH-1:0] opnd_val;
    logic [2:0]             t0_type, t1_type;
    logic [VALUE_WIDTH-1:0] t0_val, t1_val;
    logic [1:0]             n_push;

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    byte_d      = byte_q;
    byte_full_d = byte_full_q;
    overrun_d   = 1'b0;
    fifo_cnt_d  = fifo_cnt_q;
    e0_type_d   = e0_type_q;
    e0_val_d    = e0_val_q;
    e1_type_d   = e1_type_q;
    e1_val_d    = e1_val_q;
    capture     = 1'b0;

    is_digit = (byte_q >= DATA_BITS'(8'h30)) && (byte_q <= DATA_BITS'(8'h39));
    is_ws    = is_char(byte_q, 8'h20) || is_char(byte_q, 8'h09);
    is_clear = is_char(byte_q, 8'h63) || is_char(byte_q, 8'h43);
    is_op    = 1'b1;
    op_type  = TOK_EVAL;
    if      (is_char(byte_q, 8'h2B))                            op_type = TOK_ADD;
    else if (is_char(byte_q, 8'h2D))                            op_type = TOK_SUB;
    else if (is_char(byte_q, 8'h2A))                            op_type = TOK_MUL;
    else if (is_char(byte_q, 8'h2F))                            op_type = TOK_DIV;
    else if (is_char(byte_q, 8'h0D) || is_char(byte_q, 8'h0A)) op_type = TOK_EVAL;
    else                                                        is_op   = 1'b0;

    // Token for the operand in progress; an overflowed operand reports error 1
    opnd_type = ovf_q ? TOK_ERROR : TOK_NUM;
    opnd_val  = ovf_q ? VALUE_WIDTH'(1) : acc_q;

    pop = (fifo_cnt_q != 2'd0) && i_tok_ready;
    // A byte may emit two tokens, so it is only taken once the FIFO is
    // guaranteed empty after this edge's pop. Pushes therefore always land
    // in an empty FIFO, which keeps the write logic trivial.
    consume = byte_full_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop));

    if (pop) begin
      e0_type_d  = e1_type_q;
      e0_val_d   = e1_val_q;
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end

    t0_type = TOK_ERROR;
    t0_val  = VALUE_WIDTH'(2);
    t1_type = TOK_NUM;
    t1_val  = '0;
    n_push  = 2'd0;

    if (consume) begin
      byte_full_d = 1'b0;
      if (is_digit) begin
        state_d = ST_NUM;
        if (cnt_q == CNT_W'(MAX_DIGITS)) begin
          ovf_d = 1'b1;
        end else begin
          acc_d = (acc_q << 3) + (acc_q << 1) + VALUE_WIDTH'(byte_q[3:0]);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = ST_IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        if (is_ws) begin
          if (state_q == ST_NUM) begin
            t0_type = opnd_type;
            t0_val  = opnd_val;
            n_push  = 2'd1;
          end
        end else if (is_op) begin
          if (state_q == ST_NUM) begin
            t0_type = opnd_type;
            t0_val  = opnd_val;
            t1_type = op_type;
            n_push  = 2'd2;
          end else begin
            t0_type = op_type;
            t0_val  = '0;
            n_push  = 2'd1;
          end
        end else if (is_clear) begin
          t0_type = TOK_CLEAR;
          t0_val  = '0;
          n_push  = 2'd1;
        end else begin
          n_push  = 2'd1;
        end
      end
    end

    if (n_push != 2'd0) begin
      e0_type_d  = t0_type;
      e0_val_d   = t0_val;
      e1_type_d  = t1_type;
      e1_val_d   = t1_val;
      fifo_cnt_d = n_push;
    end

    // Capture: a still-occupied byte register drops the new byte
    if (i_rx_done) begin
      if (byte_full_q && !consume) begin
        overrun_d = 1'b1;
      end else begin
        byte_d      = i_rx_data;
        byte_full_d = 1'b1;
        capture     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      byte_q      <= '0;
      byte_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      e0_type_q   <= TOK_NUM;
      e0_val_q    <= '0;
      e1_type_q   <= TOK_NUM;
      e1_val_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      byte_q      <= byte_d;
      byte_full_q <= byte_full_d;
      overrun_q   <= overrun_d;
      fifo_cnt_q  <= fifo_cnt_d;
      e0_type_q   <= e0_type_d;
      e0_val_q    <= e0_val_d;
      e1_type_q   <= e1_type_d;
      e1_val_q    <= e1_val_d;
    end
  end

  assign o_tok_valid = (fifo_cnt_q != 2'd0);
  assign o_tok_type  = e0_type_q;
  assign o_tok_value = e0_val_q;
  assign o_overrun   = overrun_q;

`ifdef RPN_LEXER_ECHO_EN
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;

  // Bytes captured while the transmitter is busy are simply not echoed
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    if (i_tx_done) begin
      busy_d = 1'b0;
    end
    if (capture && !busy_q) begin
      tx_start_d = 1'b1;
      tx_data_d  = i_rx_data;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
`else
  logic unused_tx;
  assign unused_tx  = i_tx_done | capture;
  assign o_tx_start = 1'b0;
  assign o_tx_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rpn_lexer.sv
//------------------------------------------------------------------------------
// Module     : tb_rpn_lexer
// Description: Self-checking bench for rpn_lexer. Stimulus pushes expected
//              tokens into a scoreboard; a monitor pops and compares on every
//              accepted token.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rpn_lexer;

  localparam int DATA_BITS   = 8;
  localparam int VALUE_WIDTH = 32;

  logic                   clk;
  logic                   rst;
  logic                   rx_done;
  logic [DATA_BITS-1:0]   rx_data;
  logic                   tok_valid;
  logic                   tok_ready;
  logic [2:0]             tok_type;
  logic [VALUE_WIDTH-1:0] tok_value;
  logic                   overrun;
  logic                   tx_start;
  logic [DATA_BITS-1:0]   tx_data;
  logic                   tx_done;

  rpn_lexer #(
    .DATA_BITS  (DATA_BITS),
    .VALUE_WIDTH(VALUE_WIDTH),
    .MAX_DIGITS (9)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_done  (rx_done),
    .i_rx_data  (rx_data),
    .o_tok_valid(tok_valid),
    .i_tok_ready(tok_ready),
    .o_tok_type (tok_type),
    .o_tok_value(tok_value),
    .o_overrun  (overrun),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ovr_cnt  = 0;
  int tx_cnt   = 0;
  logic [DATA_BITS-1:0] tx_last = '0;

  logic [2:0]             q_type[$];
  logic [VALUE_WIDTH-1:0] q_val[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_tok(input logic [2:0] t, input logic [VALUE_WIDTH-1:0] v);
    q_type.push_back(t);
    q_val.push_back(v);
  endtask

  // Monitor: samples on the falling edge, a handshake here completes at the next rising edge
  always @(negedge clk) begin
    logic [2:0]             et;
    logic [VALUE_WIDTH-1:0] ev;
    if (overrun) ovr_cnt++;
    if (tx_start) begin
      tx_cnt++;
      tx_last = tx_data;
    end
    if (!rst && tok_valid && tok_ready) begin
      checks++;
      if (q_type.size() == 0) begin
        failures++;
        $display("FAIL unexpected_token: got type=%0d value=%0d expected none", tok_type, tok_value);
      end else begin
        et = q_type.pop_front();
        ev = q_val.pop_front();
        if (tok_type != et || tok_value != ev) begin
          failures++;
          $display("FAIL token: got type=%0d value=%0d expected type=%0d value=%0d",
                   tok_type, tok_value, et, ev);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q_type.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    idle(4);
    chk(nm, q_type.size(), 0);
  endtask

  int ovr0;

  initial begin
    rst       = 1'b1;
    rx_done   = 1'b0;
    rx_data   = '0;
    tok_ready = 1'b1;
    tx_done   = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state
    chk("reset_valid",    tok_valid, 0);
    chk("reset_type",     tok_type,  0);
    chk("reset_value",    tok_value, 0);
    chk("reset_overrun",  overrun,   0);
    chk("reset_tx_start", tx_start,  0);
    chk("reset_tx_data",  tx_data,   0);

    // Echo path (first, while the transmitter is idle)
    expect_tok(3'd0, 4);
    send("4");
`ifdef RPN_LEXER_ECHO_EN
    chk("echo1_count", tx_cnt, 1);
    chk("echo1_data",  tx_last, 8'h34);
    tx_done = 1'b1;
    idle(1);
    tx_done = 1'b0;
    send(" ");
    chk("echo2_count", tx_cnt, 2);
    chk("echo2_data",  tx_last, 8'h20);
    expect_tok(3'd0, 5);
    send_str("5 ");
    chk("echo_skipped", tx_cnt, 2);
`else
    send(" ");
    expect_tok(3'd0, 5);
    send_str("5 ");
    chk("no_echo_count", tx_cnt, 0);
    chk("no_echo_data",  tx_data, 0);
`endif
    drain("drain_echo");

    // Basic expression
    ovr0 = ovr_cnt;
    expect_tok(3'd0, 123);
    expect_tok(3'd0, 45);
    expect_tok(3'd1, 0);
    expect_tok(3'd5, 0);
    send_str("123 45+");
    send(8'h0D);
    drain("drain_expr");
    chk("expr_no_overrun", ovr_cnt - ovr0, 0);

    // SUB, DIV, TAB, CRLF, leading zeros
    expect_tok(3'd0, 6);
    expect_tok(3'd0, 2);
    expect_tok(3'd2, 0);
    expect_tok(3'd0, 9);
    expect_tok(3'd4, 0);
    expect_tok(3'd5, 0);
    expect_tok(3'd5, 0);
    expect_tok(3'd0, 7);
    send_str("6");
    send(8'h09);
    send_str("2-009/");
    send(8'h0D);
    send(8'h0A);
    send_str("007 ");
    drain("drain_ops");

    // Back-pressure: head holds while not ready
    tok_ready = 1'b0;
    send_str("7*");
    chk("hold_valid", tok_valid, 1);
    chk("hold_type",  tok_type,  0);
    chk("hold_value", tok_value, 7);
    idle(5);
    chk("hold2_valid", tok_valid, 1);
    chk("hold2_type",  tok_type,  0);
    chk("hold2_value", tok_value, 7);
    expect_tok(3'd0, 7);
    expect_tok(3'd3, 0);
    tok_ready = 1'b1;
    drain("drain_hold");
    chk("hold_empty_valid", tok_valid, 0);

    // Digit overflow, then a normal operand
    expect_tok(3'd7, 1);
    expect_tok(3'd0, 5);
    send_str("1234567890 5 ");
    drain("drain_ovf");

    // Max-length operand still fits
    expect_tok(3'd0, 999999999);
    send_str("999999999 ");
    drain("drain_max");

    // Overrun: FIFO full and byte register occupied
    tok_ready = 1'b0;
    send_str("8+");
    ovr0 = ovr_cnt;
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = "9";
    @(posedge clk); #1;
    rx_data = "-";
    @(posedge clk); #1;
    rx_done = 1'b0;
    idle(4);
    chk("overrun_pulse", ovr_cnt - ovr0, 1);
    expect_tok(3'd0, 8);
    expect_tok(3'd1, 0);
    expect_tok(3'd0, 9);
    tok_ready = 1'b1;
    idle(4);
    send(" ");
    drain("drain_overrun");

    // Invalid char and clear discard the partial operand
    expect_tok(3'd7, 2);
    expect_tok(3'd6, 0);
    send_str("12x12c");
    drain("drain_err_clr");

    // Reset mid-operand
    send_str("98");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_valid", tok_valid, 0);
    send(" ");
    idle(4);
    chk("midreset_no_token", tok_valid, 0);
    expect_tok(3'd0, 3);
    send_str("3 ");
    drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
